// File: rtl/mem_ctrl_if.sv
// Host-side word bus between mem_ctrl and the backing memory.
// The master drives word requests; the slave grants them and returns read data in order.
interface mem_ctrl_if;
   logic        host_req;
   logic        host_we;
   logic [31:0] host_addr;
   logic [31:0] host_wdata;
   logic        host_gnt;
   logic        host_rvld;
   logic [31:0] host_rdata;

   modport master (
      output host_req, host_we, host_addr, host_wdata,
      input  host_gnt, host_rvld, host_rdata
   );

   modport slave (
      input  host_req, host_we, host_addr, host_wdata,
      output host_gnt, host_rvld, host_rdata
   );
endinterface

// File: rtl/mem_ctrl.sv
// Line-level memory controller: turns 64-byte fill/writeback requests into 16 host word
// transactions, with up to 16 reads outstanding and in-order read returns.
module mem_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_vld_i,
   input  logic        req_wr_i,
   input  logic [31:0] req_addr_i,
   input  logic [31:0] wr_line_i [0:15],
   output logic        ready_o,
   output logic        tx_done_o,
   output logic [31:0] rd_line_o [0:15],
   mem_ctrl_if.master  host
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_WRITE = 2'd1,
      ST_READ  = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic [25:0] tag_q, tag_d;
   logic [4:0]  cnt_q, cnt_d;
   logic [4:0]  rcnt_q, rcnt_d;
   logic [31:0] rd_line_q [0:15];
   logic        ready_q, ready_d;
   logic        tx_done_q, tx_done_d;
   logic        host_req_q, host_req_d;
   logic        host_we_q, host_we_d;
   logic [31:0] host_addr_q, host_addr_d;
   logic [31:0] host_wdata_q, host_wdata_d;
   logic        gnt_s;
   logic        rvld_s;
   logic        rd_wr_en_s;

   assign gnt_s  = host_req_q & host.host_gnt;
   // A return is only legal for a word already granted, so rcnt can never pass cnt.
   assign rvld_s = (state_q == ST_READ) && host.host_rvld && (rcnt_q < cnt_q);

   // Next-state logic for the transfer FSM and its counters.
   always_comb begin
      state_d    = state_q;
      tag_d      = tag_q;
      cnt_d      = cnt_q;
      rcnt_d     = rcnt_q;
      rd_wr_en_s = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (req_vld_i) begin
               tag_d   = req_addr_i[31:6];
               cnt_d   = 5'd0;
               rcnt_d  = 5'd0;
               state_d = req_wr_i ? ST_WRITE : ST_READ;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_WRITE: begin
            if (gnt_s) begin
               cnt_d   = cnt_q + 5'd1;
               state_d = (cnt_q == 5'd15) ? ST_DONE : ST_WRITE;
            end else begin
               state_d = ST_WRITE;
            end
         end
         ST_READ: begin
            if (gnt_s) begin
               cnt_d = cnt_q + 5'd1;
            end else begin
               cnt_d = cnt_q;
            end
            if (rvld_s) begin
               rcnt_d     = rcnt_q + 5'd1;
               rd_wr_en_s = 1'b1;
               state_d    = (rcnt_q == 5'd15) ? ST_DONE : ST_READ;
            end else begin
               state_d = ST_READ;
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Registered outputs are precomputed from the next state so they line up with it.
   always_comb begin
      host_req_d   = (state_d == ST_WRITE) || ((state_d == ST_READ) && (cnt_d < 5'd16));
      host_we_d    = (state_d == ST_WRITE);
      host_addr_d  = host_req_d ? {tag_d, cnt_d[3:0], 2'b00} : 32'd0;
      host_wdata_d = (state_d == ST_WRITE) ? wr_line_i[cnt_d[3:0]] : 32'd0;
      ready_d      = (state_d == ST_IDLE);
      tx_done_d    = (state_d == ST_DONE);
   end

   // State, counter and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         tag_q        <= 26'd0;
         cnt_q        <= 5'd0;
         rcnt_q       <= 5'd0;
         ready_q      <= 1'b1;
         tx_done_q    <= 1'b0;
         host_req_q   <= 1'b0;
         host_we_q    <= 1'b0;
         host_addr_q  <= 32'd0;
         host_wdata_q <= 32'd0;
      end else begin
         state_q      <= state_d;
         tag_q        <= tag_d;
         cnt_q        <= cnt_d;
         rcnt_q       <= rcnt_d;
         ready_q      <= ready_d;
         tx_done_q    <= tx_done_d;
         host_req_q   <= host_req_d;
         host_we_q    <= host_we_d;
         host_addr_q  <= host_addr_d;
         host_wdata_q <= host_wdata_d;
      end
   end

   // Fill line buffer; holds its contents until the next fill overwrites it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 16; i++) begin
            rd_line_q[i] <= 32'd0;
         end
      end else if (rd_wr_en_s) begin
         rd_line_q[rcnt_q[3:0]] <= host.host_rdata;
      end
   end

   assign ready_o         = ready_q;
   assign tx_done_o       = tx_done_q;
   assign rd_line_o       = rd_line_q;
   assign host.host_req   = host_req_q;
   assign host.host_we    = host_we_q;
   assign host.host_addr  = host_addr_q;
   assign host.host_wdata = host_wdata_q;

endmodule

// File: tb/tb_mem_ctrl.sv
// Scoreboard bench for mem_ctrl: expected host words and line data are queued when a
// request is issued and compared as the DUT produces grants and completes transfers.
module tb_mem_ctrl;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_vld;
   logic        req_wr;
   logic [31:0] req_addr;
   logic [31:0] wr_line [0:15];
   logic        ready;
   logic        tx_done;
   logic [31:0] rd_line [0:15];

   int checks = 0;
   int failures = 0;
   logic [64:0] obs_q[$];
   logic [64:0] exp_q[$];
   logic [31:0] exp_line [0:15];

   mem_ctrl_if bus();

   mem_ctrl dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_vld_i (req_vld),
      .req_wr_i  (req_wr),
      .req_addr_i(req_addr),
      .wr_line_i (wr_line),
      .ready_o   (ready),
      .tx_done_o (tx_done),
      .rd_line_o (rd_line),
      .host      (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL global_timeout");
      $fatal(1, "simulation time limit exceeded");
   end

   // Host model: grants every gnt_period cycles, returns read data rvld_lat cycles after each grant.
   task automatic run_host(input int gnt_period, input int rvld_lat, input logic [31:0] data_base,
                           input int max_cyc, output int done_cyc, output int unstable);
      int cyc;
      int ridx;
      int due_q[$];
      logic prev_req, prev_gnt, gnt, rv;
      logic [64:0] prev_v, cur;
      done_cyc = 0; unstable = 0; cyc = 0; ridx = 0;
      prev_req = 1'b0; prev_gnt = 1'b0; prev_v = 65'd0;
      while (cyc < max_cyc) begin
         cyc++;
         if (tx_done) begin
            done_cyc = cyc;
            break;
         end
         cur = {bus.host_we, bus.host_addr, bus.host_wdata};
         if (prev_req && !prev_gnt && bus.host_req && (cur !== prev_v)) unstable++;
         gnt = bus.host_req && ((cyc % gnt_period) == 0);
         if (gnt) begin
            obs_q.push_back(cur);
            if (!bus.host_we) due_q.push_back(cyc + rvld_lat);
         end
         rv = 1'b0;
         if (due_q.size() > 0 && due_q[0] <= cyc) begin
            rv = 1'b1;
            void'(due_q.pop_front());
         end
         bus.host_gnt   = gnt;
         bus.host_rvld  = rv;
         bus.host_rdata = rv ? (data_base + 32'(ridx)) : 32'd0;
         if (rv) ridx++;
         prev_req = bus.host_req; prev_gnt = gnt; prev_v = cur;
         @(negedge clk);
      end
      bus.host_gnt = 1'b0; bus.host_rvld = 1'b0; bus.host_rdata = 32'd0;
   endtask

   task automatic issue(input logic wr, input logic [31:0] addr);
      req_vld = 1'b1; req_wr = wr; req_addr = addr;
      @(negedge clk);
      req_vld = 1'b0;
   endtask

   task automatic test_reset();
      int nz;
      @(negedge clk); @(negedge clk);
      nz = 0;
      for (int i = 0; i < 16; i++) if (rd_line[i] !== 32'd0) nz++;
      checks++; if (ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", ready); end
      checks++; if (tx_done !== 1'b0) begin failures++; $display("FAIL rst_tx_done got=%b exp=0", tx_done); end
      checks++;
      if ({bus.host_req, bus.host_we, bus.host_addr, bus.host_wdata} !== 66'd0) begin
         failures++;
         $display("FAIL rst_host got req=%b we=%b addr=%h wdata=%h exp all 0",
                  bus.host_req, bus.host_we, bus.host_addr, bus.host_wdata);
      end
      checks++; if (nz != 0) begin failures++; $display("FAIL rst_rd_line nonzero=%0d exp=0", nz); end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_fill();
      int done_cyc, unstable;
      logic [64:0] o, e;
      for (int i = 0; i < 16; i++) begin
         exp_q.push_back({1'b0, 32'h0000_1040 + (32'(i) << 2), 32'd0});
         exp_line[i] = 32'h0000_00A0 + 32'(i);
      end
      issue(1'b0, 32'h0000_1047);
      run_host(1, 2, 32'h0000_00A0, 100, done_cyc, unstable);
      checks++; if (done_cyc != 19) begin failures++; $display("FAIL fill_latency got=%0d exp=19", done_cyc); end
      for (int i = 0; i < 16; i++) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : 65'h1_FFFF_FFFF_FFFF_FFFF;
         checks++; if (o !== e) begin failures++; $display("FAIL fill_word%0d got=%h exp=%h", i, o, e); end
      end
      checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL fill_extra_grants got=%0d exp=0", obs_q.size()); end
      obs_q.delete();
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (rd_line[i] !== exp_line[i]) begin failures++; $display("FAIL fill_rd_line%0d got=%h exp=%h", i, rd_line[i], exp_line[i]); end
      end
      @(negedge clk);
      checks++; if (tx_done !== 1'b0) begin failures++; $display("FAIL fill_single_pulse got=%b exp=0", tx_done); end
      checks++; if (ready !== 1'b1) begin failures++; $display("FAIL fill_ready_after got=%b exp=1", ready); end
   endtask

   task automatic test_write();
      int done_cyc, unstable;
      logic [64:0] o, e;
      for (int i = 0; i < 16; i++) begin
         wr_line[i] = 32'h0000_0100 + 32'(i);
         exp_q.push_back({1'b1, 32'h0000_2000 + (32'(i) << 2), 32'h0000_0100 + 32'(i)});
      end
      issue(1'b1, 32'h0000_2000);
      run_host(2, 1, 32'd0, 100, done_cyc, unstable);
      checks++; if (done_cyc == 0) begin failures++; $display("FAIL wr_done got=timeout exp=tx_done"); end
      checks++; if (unstable != 0) begin failures++; $display("FAIL wr_stall_stable got=%0d changes exp=0", unstable); end
      for (int i = 0; i < 16; i++) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : 65'h1_FFFF_FFFF_FFFF_FFFF;
         checks++; if (o !== e) begin failures++; $display("FAIL wr_word%0d got=%h exp=%h", i, o, e); end
      end
      checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL wr_extra_grants got=%0d exp=0", obs_q.size()); end
      obs_q.delete();
      @(negedge clk);
      checks++; if (tx_done !== 1'b0 || ready !== 1'b1) begin
         failures++; $display("FAIL wr_after got tx_done=%b ready=%b exp 0/1", tx_done, ready);
      end
      checks++; if (bus.host_wdata !== 32'd0) begin failures++; $display("FAIL wr_wdata_idle got=%h exp=0", bus.host_wdata); end
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (rd_line[i] !== exp_line[i]) begin failures++; $display("FAIL wr_rd_line%0d got=%h exp=%h", i, rd_line[i], exp_line[i]); end
      end
   endtask

   task automatic test_simul();
      int done_cyc, unstable;
      logic [64:0] o, e;
      for (int i = 0; i < 16; i++) begin
         exp_q.push_back({1'b0, 32'h0003_0000 + (32'(i) << 2), 32'd0});
         exp_line[i] = 32'h0000_C000 + 32'(i);
      end
      issue(1'b0, 32'h0003_0000);
      run_host(1, 1, 32'h0000_C000, 100, done_cyc, unstable);
      checks++; if (done_cyc != 18) begin failures++; $display("FAIL simul_latency got=%0d exp=18", done_cyc); end
      for (int i = 0; i < 16; i++) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : 65'h1_FFFF_FFFF_FFFF_FFFF;
         checks++; if (o !== e) begin failures++; $display("FAIL simul_word%0d got=%h exp=%h", i, o, e); end
      end
      checks++; if (obs_q.size() != 0) begin failures++; $display("FAIL simul_extra_grants got=%0d exp=0", obs_q.size()); end
      obs_q.delete();
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (rd_line[i] !== exp_line[i]) begin failures++; $display("FAIL simul_rd_line%0d got=%h exp=%h", i, rd_line[i], exp_line[i]); end
      end
      @(negedge clk);
   endtask

   task automatic test_ignore();
      int done_cyc, unstable, bad;
      logic [64:0] o, e;
      bad = 0;
      for (int k = 0; k < 3; k++) begin
         bus.host_rvld = 1'b1; bus.host_rdata = 32'h0000_DEAD;
         @(negedge clk);
         if (ready !== 1'b1 || tx_done !== 1'b0) bad++;
      end
      bus.host_rvld = 1'b0; bus.host_rdata = 32'd0;
      for (int i = 0; i < 16; i++) if (rd_line[i] !== exp_line[i]) bad++;
      checks++; if (bad != 0) begin failures++; $display("FAIL ign_idle_rvld got=%0d diffs exp=0", bad); end
      for (int i = 0; i < 16; i++) begin
         exp_q.push_back({1'b0, 32'h0005_0080 + (32'(i) << 2), 32'd0});
         exp_line[i] = 32'h0000_5000 + 32'(i);
      end
      issue(1'b0, 32'h0005_0080);
      req_vld = 1'b1; req_wr = 1'b1; req_addr = 32'h0009_0000;
      bus.host_rvld = 1'b1; bus.host_rdata = 32'h0000_0BAD;
      checks++; if (ready !== 1'b0) begin failures++; $display("FAIL ign_ready_busy got=%b exp=0", ready); end
      @(negedge clk);
      bus.host_rvld = 1'b0; bus.host_rdata = 32'd0;
      @(negedge clk);
      checks++;
      if (bus.host_req !== 1'b1 || bus.host_we !== 1'b0 || bus.host_addr !== 32'h0005_0080) begin
         failures++;
         $display("FAIL ign_req_during_read got req=%b we=%b addr=%h exp 1/0/00050080",
                  bus.host_req, bus.host_we, bus.host_addr);
      end
      req_vld = 1'b0;
      run_host(1, 1, 32'h0000_5000, 100, done_cyc, unstable);
      checks++; if (done_cyc == 0) begin failures++; $display("FAIL ign_done got=timeout exp=tx_done"); end
      for (int i = 0; i < 16; i++) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : 65'h1_FFFF_FFFF_FFFF_FFFF;
         checks++; if (o !== e) begin failures++; $display("FAIL ign_word%0d got=%h exp=%h", i, o, e); end
      end
      obs_q.delete();
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (rd_line[i] !== exp_line[i]) begin failures++; $display("FAIL ign_rd_line%0d got=%h exp=%h", i, rd_line[i], exp_line[i]); end
      end
      @(negedge clk);
      checks++; if (ready !== 1'b1) begin failures++; $display("FAIL ign_ready_after got=%b exp=1", ready); end
   endtask

   task automatic test_reset_mid();
      int done_cyc, unstable, nz, dones;
      issue(1'b0, 32'h0007_0000);
      run_host(1, 1, 32'h0000_7700, 7, done_cyc, unstable);
      checks++; if (obs_q.size() != 7) begin failures++; $display("FAIL rstmid_grants got=%0d exp=7", obs_q.size()); end
      obs_q.delete();
      rst_n = 1'b0;
      #1;
      nz = 0;
      for (int i = 0; i < 16; i++) if (rd_line[i] !== 32'd0) nz++;
      checks++;
      if (ready !== 1'b1 || tx_done !== 1'b0 || bus.host_req !== 1'b0 || bus.host_addr !== 32'd0) begin
         failures++;
         $display("FAIL rstmid_state got ready=%b done=%b req=%b addr=%h exp 1/0/0/0",
                  ready, tx_done, bus.host_req, bus.host_addr);
      end
      checks++; if (nz != 0) begin failures++; $display("FAIL rstmid_rd_line nonzero=%0d exp=0", nz); end
      @(negedge clk);
      rst_n = 1'b1;
      dones = 0;
      for (int k = 0; k < 4; k++) begin
         bus.host_rvld = 1'b1; bus.host_rdata = 32'h0000_7777;
         @(negedge clk);
         if (tx_done !== 1'b0) dones++;
      end
      bus.host_rvld = 1'b0; bus.host_rdata = 32'd0;
      nz = 0;
      for (int i = 0; i < 16; i++) begin
         exp_line[i] = 32'd0;
         if (rd_line[i] !== 32'd0) nz++;
      end
      checks++; if (dones != 0) begin failures++; $display("FAIL rstmid_no_done got=%0d pulses exp=0", dones); end
      checks++; if (nz != 0 || ready !== 1'b1) begin
         failures++; $display("FAIL rstmid_late_rvld got nonzero=%0d ready=%b exp 0/1", nz, ready);
      end
   endtask

   task automatic test_back_to_back();
      int done_cyc, unstable;
      logic [64:0] o, e;
      for (int i = 0; i < 16; i++) begin
         wr_line[i] = 32'h0000_0200 + 32'(i);
         exp_q.push_back({1'b1, 32'h0006_0040 + (32'(i) << 2), 32'h0000_0200 + 32'(i)});
      end
      for (int i = 0; i < 16; i++) begin
         exp_q.push_back({1'b0, 32'h0008_0000 + (32'(i) << 2), 32'd0});
         exp_line[i] = 32'h0000_9000 + 32'(i);
      end
      req_vld = 1'b1; req_wr = 1'b1; req_addr = 32'h0006_0040;
      @(negedge clk);
      req_wr = 1'b0; req_addr = 32'h0008_0000;
      run_host(1, 1, 32'd0, 100, done_cyc, unstable);
      checks++; if (done_cyc == 0 || ready !== 1'b0) begin
         failures++; $display("FAIL b2b_first_done got cyc=%0d ready=%b exp done/0", done_cyc, ready);
      end
      @(negedge clk);
      checks++; if (ready !== 1'b1 || tx_done !== 1'b0) begin
         failures++; $display("FAIL b2b_idle got ready=%b done=%b exp 1/0", ready, tx_done);
      end
      @(negedge clk);
      req_vld = 1'b0;
      checks++;
      if (ready !== 1'b0 || bus.host_req !== 1'b1 || bus.host_we !== 1'b0 || bus.host_addr !== 32'h0008_0000) begin
         failures++;
         $display("FAIL b2b_accept got ready=%b req=%b we=%b addr=%h exp 0/1/0/00080000",
                  ready, bus.host_req, bus.host_we, bus.host_addr);
      end
      run_host(1, 1, 32'h0000_9000, 100, done_cyc, unstable);
      checks++; if (done_cyc == 0) begin failures++; $display("FAIL b2b_second_done got=timeout exp=tx_done"); end
      for (int i = 0; i < 32; i++) begin
         e = exp_q.pop_front();
         o = (obs_q.size() > 0) ? obs_q.pop_front() : 65'h1_FFFF_FFFF_FFFF_FFFF;
         checks++; if (o !== e) begin failures++; $display("FAIL b2b_word%0d got=%h exp=%h", i, o, e); end
      end
      obs_q.delete();
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (rd_line[i] !== exp_line[i]) begin failures++; $display("FAIL b2b_rd_line%0d got=%h exp=%h", i, rd_line[i], exp_line[i]); end
      end
      @(negedge clk);
   endtask

   initial begin
      req_vld = 1'b0; req_wr = 1'b0; req_addr = 32'd0;
      bus.host_gnt = 1'b0; bus.host_rvld = 1'b0; bus.host_rdata = 32'd0;
      for (int i = 0; i < 16; i++) begin
         wr_line[i] = 32'd0;
         exp_line[i] = 32'd0;
      end
      test_reset();
      test_fill();
      test_write();
      test_simul();
      test_ignore();
      test_reset_mid();
      test_back_to_back();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
